// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control - multicycle CPU control FSM with fetch/data handshakes
// Optional: define INSTR_COUNT_EN to enable the retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    input  logic [2:0]  opcode_i,
    input  logic        zero_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        irwrite_o,
    output logic        pcwrite_o,
    output logic        pcsrc_o,
    output logic        reg2loc_o,
    output logic        memread_o,
    output logic        memwrite_o,
    output logic        memtoreg_o,
    output logic        alusrc_o,
    output logic        regwrite_o,
    output logic [2:0]  alu_select_o,
    output logic        illegal_op_o,
    output logic        busy_o,
    output logic [15:0] instr_count_o
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ILL  = 3'd2;
    localparam logic [2:0] OP_LD   = 3'd3;
    localparam logic [2:0] OP_ST   = 3'd4;
    localparam logic [2:0] OP_CBZ  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_ANDI = 3'd7;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_PASS = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        imem_req_o   = 1'b0;
        dmem_req_o   = 1'b0;
        irwrite_o    = 1'b0;
        pcwrite_o    = 1'b0;
        pcsrc_o      = 1'b0;
        reg2loc_o    = 1'b0;
        memread_o    = 1'b0;
        memwrite_o   = 1'b0;
        memtoreg_o   = 1'b0;
        alusrc_o     = 1'b0;
        regwrite_o   = 1'b0;
        alu_select_o = ALU_ADD;
        illegal_op_o = 1'b0;
        busy_o       = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (run_i) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    irwrite_o = 1'b1;
                    state_d   = S_DECODE;
                end
            end

            // The IR is loaded by now, so the live opcode is decoded here and latched.
            S_DECODE: begin
                op_d      = opcode_i;
                reg2loc_o = (opcode_i == OP_ST) || (opcode_i == OP_CBZ);
                if (opcode_i == OP_ILL) begin
                    illegal_op_o = 1'b1;
                    pcwrite_o    = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_SUB:  alu_select_o = ALU_SUB;
                    OP_CBZ:  alu_select_o = ALU_PASS;
                    OP_ANDI: alu_select_o = ALU_AND;
                    default: alu_select_o = ALU_ADD;
                endcase
                alusrc_o = (op_q == OP_LD) || (op_q == OP_ST) ||
                           (op_q == OP_ADDI) || (op_q == OP_ANDI);
                case (op_q)
                    OP_ADD, OP_SUB, OP_ADDI, OP_ANDI: state_d = S_WB;
                    OP_LD, OP_ST:                     state_d = S_MEM;
                    OP_CBZ: begin
                        pcwrite_o = 1'b1;
                        pcsrc_o   = zero_i;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                dmem_req_o   = 1'b1;
                memread_o    = (op_q == OP_LD);
                memwrite_o   = (op_q == OP_ST);
                alusrc_o     = 1'b1;
                alu_select_o = ALU_ADD;
                if (dmem_ack_i) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        pcwrite_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end

            S_WB: begin
                regwrite_o = 1'b1;
                pcwrite_o  = 1'b1;
                memtoreg_o = (op_q == OP_LD);
                state_d    = S_FETCH;
            end

            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] count_q;

    // Every retired instruction writes the PC exactly once, so pcwrite marks retirement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else if (pcwrite_o) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count_o = count_q;
`else
    assign instr_count_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control - randomized scoreboard bench for multicycle_control
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic        run_i;
    logic [2:0]  opcode_i;
    logic        zero_i;
    logic        imem_ack_i;
    logic        dmem_ack_i;
    logic        imem_req_o, dmem_req_o, irwrite_o, pcwrite_o, pcsrc_o;
    logic        reg2loc_o, memread_o, memwrite_o, memtoreg_o, alusrc_o;
    logic        regwrite_o, illegal_op_o, busy_o;
    logic [2:0]  alu_select_o;
    logic [15:0] instr_count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_issued = 0;

    multicycle_control dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run_i),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .imem_ack_i   (imem_ack_i),
        .dmem_ack_i   (dmem_ack_i),
        .imem_req_o   (imem_req_o),
        .dmem_req_o   (dmem_req_o),
        .irwrite_o    (irwrite_o),
        .pcwrite_o    (pcwrite_o),
        .pcsrc_o      (pcsrc_o),
        .reg2loc_o    (reg2loc_o),
        .memread_o    (memread_o),
        .memwrite_o   (memwrite_o),
        .memtoreg_o   (memtoreg_o),
        .alusrc_o     (alusrc_o),
        .regwrite_o   (regwrite_o),
        .alu_select_o (alu_select_o),
        .illegal_op_o (illegal_op_o),
        .busy_o       (busy_o),
        .instr_count_o(instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instruction summary of what the control unit must produce.
    typedef struct {
        int op;
        int cyc;
        int irw;
        int pcsrc;
        int regw;
        int memw;
        int memr;
        int mtr;
        int ill;
        int alu;
        int alusrc;
        int r2l;
        int ireq;
        int dreq;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t model(int op, int z, int id, int dd);
        exp_t e;
        e = '{op: op, cyc: 0, irw: 1, pcsrc: 0, regw: 0, memw: 0, memr: 0, mtr: 0,
              ill: 0, alu: 0, alusrc: 0, r2l: 0, ireq: id + 1, dreq: 0};
        case (op)
            2: begin
                e.cyc = id + 2;
                e.ill = 1;
            end
            5: begin
                e.cyc   = id + 3;
                e.pcsrc = z;
                e.alu   = 2;
                e.r2l   = 1;
            end
            3: begin
                e.cyc    = id + dd + 5;
                e.memr   = dd + 1;
                e.dreq   = dd + 1;
                e.regw   = 1;
                e.mtr    = 1;
                e.alusrc = 1;
            end
            4: begin
                e.cyc    = id + dd + 4;
                e.memw   = dd + 1;
                e.dreq   = dd + 1;
                e.alusrc = 1;
                e.r2l    = 1;
            end
            default: begin
                e.cyc    = id + 4;
                e.regw   = 1;
                e.alu    = (op == 1) ? 1 : ((op == 7) ? 4 : 0);
                e.alusrc = (op == 6 || op == 7) ? 1 : 0;
            end
        endcase
        return e;
    endfunction

    // Monitor: accumulates one instruction's activity and retires it on pcwrite.
    exp_t acc;
    int   acc_stray_pcsrc;
    int   acc_both;

    function automatic void clear_acc();
        acc = '{op: 0, cyc: 0, irw: 0, pcsrc: 0, regw: 0, memw: 0, memr: 0, mtr: 0,
                ill: 0, alu: 0, alusrc: 0, r2l: 0, ireq: 0, dreq: 0};
        acc_stray_pcsrc = 0;
        acc_both        = 0;
    endfunction

    initial clear_acc();

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !busy_o) begin
            chk("idle_outputs_zero",
                int'({imem_req_o, dmem_req_o, irwrite_o, pcwrite_o, pcsrc_o, reg2loc_o,
                      memread_o, memwrite_o, memtoreg_o, alusrc_o, regwrite_o,
                      alu_select_o, illegal_op_o, busy_o}), 0);
            clear_acc();
        end else begin
            acc.cyc    += 1;
            acc.irw    += int'(irwrite_o);
            acc.regw   += int'(regwrite_o);
            acc.memw   += int'(memwrite_o);
            acc.memr   += int'(memread_o);
            acc.mtr    += int'(memtoreg_o);
            acc.ill    += int'(illegal_op_o);
            acc.ireq   += int'(imem_req_o);
            acc.dreq   += int'(dmem_req_o);
            acc.alu    |= int'(alu_select_o);
            acc.alusrc |= int'(alusrc_o);
            acc.r2l    |= int'(reg2loc_o);
            acc_both   += int'(regwrite_o & memwrite_o);
            if (!pcwrite_o) acc_stray_pcsrc += int'(pcsrc_o);
            if (pcwrite_o) begin
                acc.pcsrc = int'(pcsrc_o);
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d cycles", e.op),         acc.cyc,    e.cyc);
                    chk($sformatf("op%0d irwrite", e.op),        acc.irw,    e.irw);
                    chk($sformatf("op%0d pcsrc", e.op),          acc.pcsrc,  e.pcsrc);
                    chk($sformatf("op%0d regwrite", e.op),       acc.regw,   e.regw);
                    chk($sformatf("op%0d memwrite", e.op),       acc.memw,   e.memw);
                    chk($sformatf("op%0d memread", e.op),        acc.memr,   e.memr);
                    chk($sformatf("op%0d memtoreg", e.op),       acc.mtr,    e.mtr);
                    chk($sformatf("op%0d illegal_op", e.op),     acc.ill,    e.ill);
                    chk($sformatf("op%0d alu_select", e.op),     acc.alu,    e.alu);
                    chk($sformatf("op%0d alusrc", e.op),         acc.alusrc, e.alusrc);
                    chk($sformatf("op%0d reg2loc", e.op),        acc.r2l,    e.r2l);
                    chk($sformatf("op%0d imem_req", e.op),       acc.ireq,   e.ireq);
                    chk($sformatf("op%0d dmem_req", e.op),       acc.dreq,   e.dreq);
                    chk($sformatf("op%0d stray_pcsrc", e.op),    acc_stray_pcsrc, 0);
                    chk($sformatf("op%0d regwr_memwr", e.op),    acc_both,   0);
                end
                clear_acc();
            end
        end
    end

    // Driver: one instruction with given imem/dmem ack delays; spurious acks when idle.
    task automatic run_instr(input int op, input int z, input int id, input int dd);
        int  icnt = 0;
        int  dcnt = 0;
        bit  done = 0;
        exp_q.push_back(model(op, z, id, dd));
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #2;
            if (c == 0) begin
                opcode_i = 3'(op);
                zero_i   = 1'(z);
            end
            run_i = 1'($urandom_range(1, 0));
            if (imem_req_o) begin
                imem_ack_i = (icnt == id);
                icnt++;
            end else begin
                imem_ack_i = 1'($urandom_range(1, 0));
            end
            if (dmem_req_o) begin
                dmem_ack_i = (dcnt == dd);
                dcnt++;
            end else begin
                dmem_ack_i = 1'($urandom_range(1, 0));
            end
            #1;
            if (pcwrite_o) done = 1;
        end
        if (!done) chk($sformatf("op%0d timeout", op), 0, 1);
        n_issued++;
    endtask

    task automatic start_run();
        @(posedge clk); #2;
        run_i      = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
    endtask

    task automatic do_reset_release();
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("idle_without_run_busy", int'(busy_o), 0);
        chk("idle_counter_zero", int'(instr_count_o), 0);
    endtask

    task automatic random_block(input int n);
        for (int i = 0; i < n; i++) begin
            run_instr($urandom_range(7, 0), $urandom_range(1, 0),
                      $urandom_range(3, 0), $urandom_range(3, 0));
        end
    endtask

    initial begin
        bit seen;
        int exp_cnt;
        rst_n      = 1'b0;
        run_i      = 1'b0;
        opcode_i   = 3'd0;
        zero_i     = 1'b0;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        do_reset_release();

        start_run();
        run_instr(0, 0, 0, 0);
        run_instr(3, 0, 0, 3);
        run_instr(5, 1, 0, 0);
        run_instr(5, 0, 0, 0);
        run_instr(2, 0, 0, 0);
        run_instr(4, 0, 0, 0);
        run_instr(1, 0, 2, 0);
        run_instr(7, 1, 0, 0);
        random_block(200);

        // Reset while a load is waiting on its data-memory handshake.
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #2;
            if (c == 0) opcode_i = 3'd3;
            imem_ack_i = imem_req_o;
            dmem_ack_i = 1'b0;
            #1;
            if (dmem_req_o) seen = 1;
        end
        chk("mem_wait_reached", int'(seen), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_dmem_req", int'(dmem_req_o), 0);
        chk("async_reset_memread", int'(memread_o), 0);
        chk("async_reset_busy", int'(busy_o), 0);
        chk("async_reset_counter", int'(instr_count_o), 0);
        n_issued = 0;
        repeat (2) @(posedge clk);
        do_reset_release();

        start_run();
        random_block(60);

        @(posedge clk); #2;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        #1;
`ifdef INSTR_COUNT_EN
        exp_cnt = n_issued & 16'hFFFF;
`else
        exp_cnt = 0;
`endif
        chk("instr_count", int'(instr_count_o), exp_cnt);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-003 run  input  1  1 = start or continue instruction sequencing; sampled only in IDLE.
REQ-004 opcode  input  3  instruction opcode from instruction register; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag; sampled in EXEC.
REQ-006 imem_req / imem_ack  output / input  1 / 1  instruction-fetch request, held until ack.
REQ-007 dmem_req / dmem_ack  output / input  1 / 1  data-memory request, held until ack.
REQ-008 irwrite, pcwrite, pcsrc  output  1 each  load IR; load PC; 0 = PC+4, 1 = branch target.
REQ-009 reg2loc, memread, memwrite, memtoreg, alusrc, regwrite  output  1 each  datapath controls.
REQ-010 alu_select  output  3  0 = ADD, 1 = SUB, 2 = pass/test B, 4 = AND.
REQ-011 illegal_op  output  1  one-cycle pulse on unsupported opcode (2).
REQ-012 busy  output  1  1 in every state except IDLE.

Function
REQ-013 States: IDLE, FETCH, DECODE, EXEC, MEM, WB; Moore outputs decoded from state and latched opcode (op_q).
REQ-014 IDLE: all outputs 0; run=1 -> FETCH next cycle, else stay.
REQ-015 FETCH: imem_req=1; stay until imem_ack=1; in the ack cycle irwrite=1, next state DECODE.
REQ-016 DECODE: op_q <= opcode; reg2loc=1 for opcodes 4,5, else 0; next EXEC (opcode 2: illegal_op=1, pcwrite=1, pcsrc=0, next FETCH).
REQ-017 EXEC: alu_select 0 for opcodes 0,3,4,6; 1 for opcode 1; 2 for opcode 5; 4 for opcode 7; alusrc=1 for opcodes 3,4,6,7.
REQ-018 EXEC transitions: opcodes 0,1,6,7 -> WB; 3,4 -> MEM; 5 -> pcwrite=1, pcsrc=zero, next FETCH.
REQ-019 MEM: dmem_req=1, memread=1 (opcode 3) or memwrite=1 (opcode 4); alusrc=1, alu_select=0 held; stay until dmem_ack=1.
REQ-020 MEM on ack: opcode 3 -> WB; opcode 4 -> pcwrite=1, pcsrc=0, next FETCH.
REQ-021 WB: regwrite=1, pcwrite=1, pcsrc=0, memtoreg=1 iff op_q=3; next FETCH.
REQ-022 Latency with immediate acks: ALU op 5 cycles, LD 6, ST 5, CBZ 4, illegal 3 (FETCH to FETCH).
REQ-023 Each completed instruction asserts pcwrite exactly once; regwrite and memwrite never both 1.
REQ-024 run is ignored outside IDLE; machine returns to IDLE only via reset.
REQ-025 ack arriving while not requested is ignored; req never deasserts before ack.
REQ-026 Outputs not named for a state are 0 in that state.

Reset
REQ-027 reset=0 -> state IDLE, op_q=0, all outputs 0, counter 0, asynchronously, including mid-handshake.
REQ-028 After reset release, first transition requires run=1 sampled on a rising edge.

Configuration
REQ-029 INSTR_COUNT_EN defined: extra output instr_count [15:0] increments on every pcwrite=1 cycle, wraps 0xFFFF->0x0000, reset 0.
REQ-030 INSTR_COUNT_EN undefined: instr_count port present, constant 0; no counter logic.

Verification
REQ-031 reset=0 mid-MEM with dmem_req=1 -> same-cycle dmem_req=0, busy=0, state IDLE.
REQ-032 run=1, opcode=0, acks tied 1 -> irwrite at cycle 1, alu_select=0 in EXEC, regwrite+pcwrite together in WB cycle 4, FETCH at cycle 5.
REQ-033 opcode=3, dmem_ack delayed 3 cycles -> dmem_req and memread high 4 cycles, then WB with memtoreg=1, regwrite=1.
REQ-034 opcode=5, zero=1 then zero=0 -> pcwrite=1 with pcsrc=1, then pcsrc=0; regwrite stays 0.
REQ-035 opcode=2 -> illegal_op one-cycle pulse in DECODE, pcwrite=1, no regwrite/memwrite, next FETCH.
REQ-036 INSTR_COUNT_EN defined, 65536 NOP-equivalent instructions -> instr_count wraps to 0x0000.
